// File: rtl/branch_predictor.sv
// branch_predictor
//   Direction predictor plus branch target buffer for the 5-stage RV64 pipeline.
//   A table of 2**IDX_W saturating counters is indexed by PC (bimodal) or by
//   PC XOR global history (gshare, GHR_W>0). A tagged BTB indexed by PC alone
//   supplies the taken target. Lookup is combinational from the IF-stage PC;
//   resolved branches from ID update the tables on the rising clock edge.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   en              global enable; low freezes all state
//   clear           synchronous invalidate (keeps mispred_cnt), needs en
//   lookup_pc       IF-stage PC
//   pred_taken      predicted taken (BTB hit and counter MSB set)
//   pred_hit        BTB hit for lookup_pc
//   pred_target     BTB target when predicted taken, else lookup_pc+4
//   pred_ghr        global history snapshot carried down the pipe
//   upd_valid       resolved conditional branch this cycle
//   upd_pc          PC of the resolved branch
//   upd_ghr         history snapshot taken at that branch's lookup
//   upd_taken       actual outcome
//   upd_target      actual taken target
//   upd_pred_taken  direction predicted for that branch
//   mispred_cnt     saturating count of direction mispredicts
module branch_predictor #(
   parameter int PC_W   = 64,
   parameter int IDX_W  = 5,
   parameter int CNT_W  = 2,
   parameter int TAG_W  = 8,
   parameter int GHR_W  = 0,
   parameter int PC_LSB = 2,
   parameter int PERF_W = 32
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 en,
   input  logic                                 clear,
   input  logic [PC_W-1:0]                      lookup_pc,
   output logic                                 pred_taken,
   output logic                                 pred_hit,
   output logic [PC_W-1:0]                      pred_target,
   output logic [((GHR_W > 0) ? GHR_W : 1)-1:0] pred_ghr,
   input  logic                                 upd_valid,
   input  logic [PC_W-1:0]                      upd_pc,
   input  logic [((GHR_W > 0) ? GHR_W : 1)-1:0] upd_ghr,
   input  logic                                 upd_taken,
   input  logic [PC_W-1:0]                      upd_target,
   input  logic                                 upd_pred_taken,
   output logic [PERF_W-1:0]                    mispred_cnt
);

   localparam int GW      = (GHR_W > 0) ? GHR_W : 1;
   localparam int ENTRIES = 1 << IDX_W;
   localparam int TAG_LSB = PC_LSB + IDX_W;
   // Weakly not-taken; collapses to 0 for a 1-bit counter.
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((1 << (CNT_W - 1)) - 1);

   if (CNT_W < 1 || CNT_W > 4) begin : g_bad_cnt_w
      $error("branch_predictor: CNT_W must be in 1..4");
   end
   if (GHR_W < 0 || GHR_W > IDX_W) begin : g_bad_ghr_w
      $error("branch_predictor: GHR_W must be in 0..IDX_W");
   end
   if (TAG_LSB + TAG_W > PC_W) begin : g_bad_tag
      $error("branch_predictor: index and tag fields exceed PC_W");
   end

   logic [ENTRIES-1:0][CNT_W-1:0] cnt;
   logic [ENTRIES-1:0]            btb_valid;
   logic [ENTRIES-1:0][TAG_W-1:0] btb_tag;
   logic [ENTRIES-1:0][PC_W-1:0]  btb_target;
   logic [GW-1:0]                 ghr;

   logic [IDX_W-1:0] l_idx, l_didx, u_idx, u_didx;
   logic [TAG_W-1:0] l_tag, u_tag;
   logic [GW-1:0]    ghr_next;
   logic [CNT_W-1:0] cnt_cur, cnt_next;

   assign l_idx = lookup_pc[TAG_LSB-1:PC_LSB];
   assign l_tag = lookup_pc[TAG_LSB+TAG_W-1:TAG_LSB];
   assign u_idx = upd_pc[TAG_LSB-1:PC_LSB];
   assign u_tag = upd_pc[TAG_LSB+TAG_W-1:TAG_LSB];

   // Only the direction table sees the history; the BTB stays PC-indexed.
   if (GHR_W > 0) begin : g_gshare
      assign l_didx = l_idx ^ IDX_W'(ghr);
      assign u_didx = u_idx ^ IDX_W'(upd_ghr);
      if (GHR_W > 1) begin : g_shift
         assign ghr_next = {ghr[GW-2:0], upd_taken};
      end else begin : g_single
         assign ghr_next = upd_taken;
      end
   end else begin : g_bimodal
      assign l_didx   = l_idx;
      assign u_didx   = u_idx;
      assign ghr_next = '0;
   end

   // Lookup: purely combinational, reflects state before this cycle's edge.
   assign pred_hit    = btb_valid[l_idx] && (btb_tag[l_idx] == l_tag);
   assign pred_taken  = pred_hit && cnt[l_didx][CNT_W-1];
   assign pred_target = pred_taken ? btb_target[l_idx] : lookup_pc + PC_W'(4);
   assign pred_ghr    = ghr;

   assign cnt_cur = cnt[u_didx];

   always_comb begin
      cnt_next = cnt_cur;
      if (upd_taken) begin
         if (cnt_cur != '1) cnt_next = cnt_cur + CNT_W'(1);
      end else begin
         if (cnt_cur != '0) cnt_next = cnt_cur - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt         <= {ENTRIES{CNT_INIT}};
         btb_valid   <= '0;
         ghr         <= '0;
         mispred_cnt <= '0;
      end else if (en) begin
         if (clear) begin
            // Same as reset but the perf counter survives.
            cnt       <= {ENTRIES{CNT_INIT}};
            btb_valid <= '0;
            ghr       <= '0;
         end else if (upd_valid) begin
            cnt[u_didx] <= cnt_next;
            if (upd_taken) begin
               btb_valid[u_idx]  <= 1'b1;
               btb_tag[u_idx]    <= u_tag;
               btb_target[u_idx] <= upd_target;
            end
            if (GHR_W > 0) ghr <= ghr_next;
            if ((upd_pred_taken != upd_taken) && (mispred_cnt != '1))
               mispred_cnt <= mispred_cnt + PERF_W'(1);
         end
      end
   end

   // Upper/lower PC bits outside idx/tag and the bimodal history input are
   // intentionally ignored.
   logic unused_bits;
   assign unused_bits = ^{upd_pc, upd_ghr, ghr_next};

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor
//   Self-checking bench for branch_predictor. Three instances share one
//   stimulus stream: default bimodal (u_dut), PERF_W=2 (u_perf) for counter
//   saturation, and GHR_W=4 (u_ghr) for gshare history. Each step pushes its
//   expected lookup result to a scoreboard when driven; the result is popped
//   and compared at the following negedge, before the step's update commits.
module tb_branch_predictor;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, en, clear, upd_valid, upd_taken, upd_pred_taken;
   logic [63:0] lookup_pc, upd_pc, upd_target;
   logic [3:0]  ug;
   logic        ug1;

   logic        d_tk, d_hit, d_ghr;
   logic [63:0] d_tgt;
   logic [31:0] d_mis;
   logic        p_tk, p_hit, p_ghr;
   logic [63:0] p_tgt;
   logic [1:0]  p_mis;
   logic        g_tk, g_hit;
   logic [63:0] g_tgt;
   logic [3:0]  g_ghr;
   logic [31:0] g_mis;

   branch_predictor u_dut (
      .clk(clk), .rst(rst), .en(en), .clear(clear), .lookup_pc(lookup_pc),
      .pred_taken(d_tk), .pred_hit(d_hit), .pred_target(d_tgt), .pred_ghr(d_ghr),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_ghr(ug1), .upd_taken(upd_taken),
      .upd_target(upd_target), .upd_pred_taken(upd_pred_taken), .mispred_cnt(d_mis)
   );

   branch_predictor #(.PERF_W(2)) u_perf (
      .clk(clk), .rst(rst), .en(en), .clear(clear), .lookup_pc(lookup_pc),
      .pred_taken(p_tk), .pred_hit(p_hit), .pred_target(p_tgt), .pred_ghr(p_ghr),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_ghr(ug1), .upd_taken(upd_taken),
      .upd_target(upd_target), .upd_pred_taken(upd_pred_taken), .mispred_cnt(p_mis)
   );

   branch_predictor #(.GHR_W(4)) u_ghr (
      .clk(clk), .rst(rst), .en(en), .clear(clear), .lookup_pc(lookup_pc),
      .pred_taken(g_tk), .pred_hit(g_hit), .pred_target(g_tgt), .pred_ghr(g_ghr),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_ghr(ug), .upd_taken(upd_taken),
      .upd_target(upd_target), .upd_pred_taken(upd_pred_taken), .mispred_cnt(g_mis)
   );

   typedef struct {
      logic        hit, tk;
      logic [63:0] tgt;
      logic [31:0] mis;
      logic [1:0]  mis2;
      logic        gv;
      logic [3:0]  ghr;
   } exp_t;

   typedef struct {
      logic        en, clr, rs, uv, ut, upt;
      logic [63:0] upc, utgt, lpc;
      logic [3:0]  ug;
      exp_t        e;
   } step_t;

   exp_t sb[$];
   int   nerr = 0;
   int   nchk = 0;

   function automatic exp_t ex(input logic hit, input logic tk, input logic [63:0] tgt,
                               input logic [31:0] mis, input logic [1:0] mis2);
      exp_t e;
      e.hit = hit; e.tk = tk; e.tgt = tgt; e.mis = mis; e.mis2 = mis2;
      e.gv = 1'b0; e.ghr = 4'h0;
      return e;
   endfunction

   function automatic exp_t exg(input exp_t b, input logic [3:0] ghr);
      exp_t e;
      e = b; e.gv = 1'b1; e.ghr = ghr;
      return e;
   endfunction

   function automatic step_t st_upd(input logic [63:0] pc, input logic tk, input logic [63:0] tgt,
                                    input logic ptk, input logic [63:0] lpc, input exp_t e);
      step_t s;
      s.en = 1'b1; s.clr = 1'b0; s.rs = 1'b0; s.uv = 1'b1; s.ut = tk; s.upt = ptk;
      s.upc = pc; s.utgt = tgt; s.lpc = lpc; s.ug = 4'h0; s.e = e;
      return s;
   endfunction

   function automatic step_t st_idle(input logic [63:0] lpc, input exp_t e);
      step_t s;
      s = st_upd(64'h0, 1'b0, 64'h0, 1'b0, lpc, e);
      s.uv = 1'b0;
      return s;
   endfunction

   // Drive one step's inputs and record what the lookup must show this cycle.
   task automatic drive(input step_t s);
      en = s.en; clear = s.clr; rst = s.rs; upd_valid = s.uv; upd_taken = s.ut;
      upd_pred_taken = s.upt; upd_pc = s.upc; upd_target = s.utgt; lookup_pc = s.lpc;
      ug = s.ug; ug1 = 1'b0;
      sb.push_back(s.e);
   endtask

   task automatic do_reset();
      step_t s;
      s = st_idle(64'h100, ex(1'b0, 1'b0, 64'h104, 32'd0, 2'd0));
      s.rs = 1'b1;
      drive(s);
      void'(sb.pop_front());
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      step_t st[$];
      exp_t  e;
      do_reset();
      do_reset();
      st.push_back(st_idle(64'h100, exg(ex(1'b0, 1'b0, 64'h104, 32'd0, 2'd0), 4'h0)));
      // pc+4 wraps modulo 2**64
      st.push_back(st_idle(64'hFFFF_FFFF_FFFF_FFFC, ex(1'b0, 1'b0, 64'h0, 32'd0, 2'd0)));
      foreach (st[i]) begin
         drive(st[i]);
         @(negedge clk);
         e = sb.pop_front();
         nchk++;
         if ({d_hit, d_tk, d_tgt, d_mis, p_mis} !== {e.hit, e.tk, e.tgt, e.mis, e.mis2}) begin
            nerr++;
            $display("FAIL reset step %0d: hit/tk/tgt/mis/mis2 got %b/%b/%h/%0d/%0d want %b/%b/%h/%0d/%0d",
                     i, d_hit, d_tk, d_tgt, d_mis, p_mis, e.hit, e.tk, e.tgt, e.mis, e.mis2);
         end
         if (e.gv) begin
            nchk++;
            if (g_ghr !== e.ghr) begin
               nerr++;
               $display("FAIL reset step %0d ghr: got %h want %h", i, g_ghr, e.ghr);
            end
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_update();
      step_t st[$];
      step_t s;
      exp_t  e;
      do_reset();
      // Same-cycle lookup sees the pre-update state.
      st.push_back(st_upd(64'h100, 1'b1, 64'h80, 1'b1, 64'h100, exg(ex(1'b0, 1'b0, 64'h104, 32'd0, 2'd0), 4'h0)));
      st.push_back(st_idle(64'h100, exg(ex(1'b1, 1'b1, 64'h80, 32'd0, 2'd0), 4'h1)));
      // Reset with a simultaneous mispredicted update: update must vanish.
      s = st_upd(64'h100, 1'b1, 64'h300, 1'b0, 64'h100, exg(ex(1'b1, 1'b1, 64'h80, 32'd0, 2'd0), 4'h1));
      s.rs = 1'b1;
      st.push_back(s);
      st.push_back(st_idle(64'h100, exg(ex(1'b0, 1'b0, 64'h104, 32'd0, 2'd0), 4'h0)));
      foreach (st[i]) begin
         drive(st[i]);
         @(negedge clk);
         e = sb.pop_front();
         nchk++;
         if ({d_hit, d_tk, d_tgt, d_mis, p_mis} !== {e.hit, e.tk, e.tgt, e.mis, e.mis2}) begin
            nerr++;
            $display("FAIL update step %0d: hit/tk/tgt/mis/mis2 got %b/%b/%h/%0d/%0d want %b/%b/%h/%0d/%0d",
                     i, d_hit, d_tk, d_tgt, d_mis, p_mis, e.hit, e.tk, e.tgt, e.mis, e.mis2);
         end
         if (e.gv) begin
            nchk++;
            if (g_ghr !== e.ghr) begin
               nerr++;
               $display("FAIL update step %0d ghr: got %h want %h", i, g_ghr, e.ghr);
            end
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_saturation();
      step_t st[$];
      exp_t  e;
      exp_t  miss, tkn, ntk;
      miss = ex(1'b0, 1'b0, 64'h104, 32'd0, 2'd0);
      tkn  = ex(1'b1, 1'b1, 64'h80,  32'd0, 2'd0);
      ntk  = ex(1'b1, 1'b0, 64'h104, 32'd0, 2'd0);
      do_reset();
      // Counter from 1: T x5 -> 3 (saturated), N -> 2, N -> 1, N,N -> 0, T -> 1, T -> 2
      st.push_back(st_upd(64'h100, 1'b1, 64'h80, 1'b1, 64'h100, miss));
      for (int k = 0; k < 4; k++) st.push_back(st_upd(64'h100, 1'b1, 64'h80, 1'b1, 64'h100, tkn));
      st.push_back(st_upd(64'h100, 1'b0, 64'h0, 1'b0, 64'h100, tkn));
      st.push_back(st_upd(64'h100, 1'b0, 64'h0, 1'b0, 64'h100, tkn));
      st.push_back(st_upd(64'h100, 1'b0, 64'h0, 1'b0, 64'h100, ntk));
      st.push_back(st_upd(64'h100, 1'b0, 64'h0, 1'b0, 64'h100, ntk));
      st.push_back(st_upd(64'h100, 1'b1, 64'h80, 1'b1, 64'h100, ntk));
      st.push_back(st_idle(64'h100, ntk));
      st.push_back(st_upd(64'h100, 1'b1, 64'h80, 1'b1, 64'h100, ntk));
      st.push_back(st_idle(64'h100, tkn));
      foreach (st[i]) begin
         drive(st[i]);
         @(negedge clk);
         e = sb.pop_front();
         nchk++;
         if ({d_hit, d_tk, d_tgt, d_mis, p_mis} !== {e.hit, e.tk, e.tgt, e.mis, e.mis2}) begin
            nerr++;
            $display("FAIL saturation step %0d: hit/tk/tgt/mis/mis2 got %b/%b/%h/%0d/%0d want %b/%b/%h/%0d/%0d",
                     i, d_hit, d_tk, d_tgt, d_mis, p_mis, e.hit, e.tk, e.tgt, e.mis, e.mis2);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_alias();
      step_t st[$];
      exp_t  e;
      do_reset();
      // 0x100 and 0x180 share idx 0 with tags 2 and 3.
      st.push_back(st_upd(64'h100, 1'b1, 64'h80,  1'b1, 64'h100, ex(1'b0, 1'b0, 64'h104, 32'd0, 2'd0)));
      st.push_back(st_upd(64'h180, 1'b1, 64'h200, 1'b1, 64'h180, ex(1'b0, 1'b0, 64'h184, 32'd0, 2'd0)));
      st.push_back(st_idle(64'h100, ex(1'b0, 1'b0, 64'h104, 32'd0, 2'd0)));
      st.push_back(st_idle(64'h180, ex(1'b1, 1'b1, 64'h200, 32'd0, 2'd0)));
      foreach (st[i]) begin
         drive(st[i]);
         @(negedge clk);
         e = sb.pop_front();
         nchk++;
         if ({d_hit, d_tk, d_tgt, d_mis, p_mis} !== {e.hit, e.tk, e.tgt, e.mis, e.mis2}) begin
            nerr++;
            $display("FAIL alias step %0d: hit/tk/tgt/mis/mis2 got %b/%b/%h/%0d/%0d want %b/%b/%h/%0d/%0d",
                     i, d_hit, d_tk, d_tgt, d_mis, p_mis, e.hit, e.tk, e.tgt, e.mis, e.mis2);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_mispredict();
      step_t st[$];
      step_t s;
      exp_t  e;
      do_reset();
      st.push_back(st_upd(64'h100, 1'b1, 64'h80, 1'b0, 64'h100, ex(1'b0, 1'b0, 64'h104, 32'd0, 2'd0)));
      s = st_upd(64'h100, 1'b1, 64'h80, 1'b0, 64'h100, ex(1'b1, 1'b1, 64'h80, 32'd1, 2'd1));
      s.en = 1'b0;
      st.push_back(s);
      st.push_back(st_upd(64'h100, 1'b0, 64'h0, 1'b1, 64'h100, ex(1'b1, 1'b1, 64'h80, 32'd1, 2'd1)));
      st.push_back(st_idle(64'h100, ex(1'b1, 1'b0, 64'h104, 32'd2, 2'd2)));
      // clear without en has no effect
      s = st_idle(64'h100, ex(1'b1, 1'b0, 64'h104, 32'd2, 2'd2));
      s.en = 1'b0; s.clr = 1'b1;
      st.push_back(s);
      // clear with a mispredicted update in the same cycle: update dropped
      s = st_upd(64'h100, 1'b1, 64'h80, 1'b0, 64'h100, ex(1'b1, 1'b0, 64'h104, 32'd2, 2'd2));
      s.clr = 1'b1;
      st.push_back(s);
      st.push_back(st_idle(64'h100, ex(1'b0, 1'b0, 64'h104, 32'd2, 2'd2)));
      s = st_idle(64'h100, ex(1'b0, 1'b0, 64'h104, 32'd2, 2'd2));
      s.rs = 1'b1;
      st.push_back(s);
      st.push_back(st_upd(64'h100, 1'b1, 64'h80, 1'b0, 64'h100, ex(1'b0, 1'b0, 64'h104, 32'd0, 2'd0)));
      st.push_back(st_upd(64'h100, 1'b1, 64'h80, 1'b0, 64'h100, ex(1'b1, 1'b1, 64'h80, 32'd1, 2'd1)));
      st.push_back(st_upd(64'h100, 1'b1, 64'h80, 1'b0, 64'h100, ex(1'b1, 1'b1, 64'h80, 32'd2, 2'd2)));
      st.push_back(st_upd(64'h100, 1'b1, 64'h80, 1'b0, 64'h100, ex(1'b1, 1'b1, 64'h80, 32'd3, 2'd3)));
      st.push_back(st_upd(64'h100, 1'b1, 64'h80, 1'b0, 64'h100, ex(1'b1, 1'b1, 64'h80, 32'd4, 2'd3)));
      st.push_back(st_idle(64'h100, ex(1'b1, 1'b1, 64'h80, 32'd5, 2'd3)));
      foreach (st[i]) begin
         drive(st[i]);
         @(negedge clk);
         e = sb.pop_front();
         nchk++;
         if ({d_hit, d_tk, d_tgt, d_mis, p_mis} !== {e.hit, e.tk, e.tgt, e.mis, e.mis2}) begin
            nerr++;
            $display("FAIL mispredict step %0d: hit/tk/tgt/mis/mis2 got %b/%b/%h/%0d/%0d want %b/%b/%h/%0d/%0d",
                     i, d_hit, d_tk, d_tgt, d_mis, p_mis, e.hit, e.tk, e.tgt, e.mis, e.mis2);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_ghr();
      step_t st[$];
      step_t s;
      exp_t  e;
      exp_t  miss;
      miss = ex(1'b0, 1'b0, 64'h104, 32'd0, 2'd0);
      do_reset();
      // History training at idx 5 (pc 0x14) with snapshot 0: T,T,N,T -> 4'hD
      st.push_back(st_upd(64'h14, 1'b1, 64'h40, 1'b1, 64'h100, exg(miss, 4'h0)));
      st.push_back(st_upd(64'h14, 1'b1, 64'h40, 1'b1, 64'h100, exg(miss, 4'h1)));
      st.push_back(st_upd(64'h14, 1'b0, 64'h0,  1'b0, 64'h100, exg(miss, 4'h3)));
      st.push_back(st_upd(64'h14, 1'b1, 64'h40, 1'b1, 64'h100, exg(miss, 4'h6)));
      s = st_upd(64'h100, 1'b1, 64'h80, 1'b1, 64'h100, exg(miss, 4'hD));
      s.ug = 4'hD;
      st.push_back(s);
      st.push_back(st_idle(64'h100, exg(ex(1'b1, 1'b1, 64'h80, 32'd0, 2'd0), 4'hB)));
      foreach (st[i]) begin
         drive(st[i]);
         @(negedge clk);
         e = sb.pop_front();
         nchk++;
         if ({d_hit, d_tk, d_tgt, d_mis, p_mis} !== {e.hit, e.tk, e.tgt, e.mis, e.mis2}) begin
            nerr++;
            $display("FAIL ghr step %0d: hit/tk/tgt/mis/mis2 got %b/%b/%h/%0d/%0d want %b/%b/%h/%0d/%0d",
                     i, d_hit, d_tk, d_tgt, d_mis, p_mis, e.hit, e.tk, e.tgt, e.mis, e.mis2);
         end
         if (e.gv) begin
            nchk++;
            if (g_ghr !== e.ghr) begin
               nerr++;
               $display("FAIL ghr step %0d pred_ghr: got %h want %h", i, g_ghr, e.ghr);
            end
         end
         @(posedge clk); #1;
      end
      // 0 ^ 4'hD = 13: only that counter moves (1 -> 2); entry 0 stays weak NT.
      nchk++;
      if (u_ghr.cnt[13] !== 2'd2) begin
         nerr++;
         $display("FAIL ghr cnt13: got %0d want 2", u_ghr.cnt[13]);
      end
      nchk++;
      if (u_ghr.cnt[0] !== 2'd1) begin
         nerr++;
         $display("FAIL ghr cnt0: got %0d want 1", u_ghr.cnt[0]);
      end
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; clear = 1'b0; upd_valid = 1'b0; upd_taken = 1'b0;
      upd_pred_taken = 1'b0; upd_pc = '0; upd_target = '0; lookup_pc = 64'h100;
      ug = '0; ug1 = 1'b0;
      @(posedge clk); #1;
      test_reset();
      test_update();
      test_saturation();
      test_alias();
      test_mispredict();
      test_ghr();
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
